eth_xgmii_tx_framer: RTL
========================

// Module: eth_xgmii_tx_framer
// PURPOSE
//  Feeds the XGMII TX side of eth_phy_10g. Converts a 64-bit AXI-Stream frame into XGMII data/control words.
//  Frames arrive complete, including FCS. Block adds start + preamble/SFD, terminate and idles.
//  Enforces the minimum IFG and signals upstream underrun with XGMII error codes.
// PARAMETERS
//  DATA_WIDTH  64  XGMII/AXIS data width; only 64 supported
//  CTRL_WIDTH  8   DATA_WIDTH/8; txc and tkeep width
//  IFG_BYTES   12  min bytes from terminate (inclusive) to next start; legal range 8..64
//  STAT_WIDTH  32  width of statistics counters
// PORTS
//  tx_clk         in   1   TX clock (same clock as eth_phy_10g tx_clk)
//  tx_rst         in   1   sync, active-high reset
//  s_axis_tdata   in   64  frame bytes; lane i = [8i+7:8i], byte 0 first
//  s_axis_tkeep   in   8   byte valid; must be 8'hFF except on tlast beat
//  s_axis_tvalid  in   1   beat valid
//  s_axis_tready  out  1   beat accepted when tvalid&tready
//  s_axis_tlast   in   1   last beat of frame
//  s_axis_tuser   in   1   on tlast beat: upstream error, corrupt frame
//  xgmii_txd      out  64  to eth_phy_10g xgmii_txd
//  xgmii_txc      out  8   to eth_phy_10g xgmii_txc; bit i = lane i is control
//  tx_underrun    out  1   1-cycle pulse: tvalid low mid-frame
//  tx_bad_keep    out  1   1-cycle pulse: illegal tkeep seen
//  stat_tx_frames out  STAT_WIDTH  frames terminated normally (see CONFIGURATION)
//  stat_tx_bytes  out  STAT_WIDTH  payload bytes incl. FCS, excl. preamble
// BEHAVIOUR
//  Reset: txd=64'h0707070707070707, txc=8'hFF, tready=0, pulses=0, stats=0, state=IDLE, IFG satisfied.
//  Outputs are registered. An accepted beat appears on xgmii one cycle later.
//  Codes: IDLE 07, START FB, TERM FD, ERROR FE, PRE 55, SFD D5. Start is on lane 0 only; no DIC.
//  States:
//   IDLE: tready=0; drives idle block.
//     If tvalid and IFG met -> PREAMBLE; next word = 64'hD5555555555555FB, txc=8'h01.
//   PREAMBLE/DATA: tready=1.
//     Non-last beat -> txd=tdata, txc=0.
//     Last beat, n=index of lowest 0 in tkeep (8 if FF):
//       n<8 -> lanes<n data, lane n FD, lanes>n 07; txc=~tkeep-style mask (lanes>=n); -> IFG with k=n.
//       n=8 -> data word, -> TERM.
//   TERM: tready=0; drives FD + 7x07, txc=FF; k=0; -> IFG.
//   IFG: tready=0; drives idle blocks.
//     Count starts at 8-k bytes from term block, +8 per idle block; -> IDLE once count>=IFG_BYTES.
//     IFG=12: k<=4 needs 1 idle block, k>=5 needs 2.
//   Underrun (tvalid=0 in PREAMBLE/DATA): drive {6x07,FD,FE} (lane0 FE, lane1 FD), txc=FF; pulse tx_underrun.
//     -> DROP with k=1.
//   DROP: tready=1, drive idles; discard beats through tlast.
//     Idles count toward IFG; after tlast -> IFG (IDLE if already met).
//  tuser=1 on last beat: all valid data lanes replaced by FE with txc set; terminate still follows; not counted.
//  tkeep!=FF on non-last beat, or non-contiguous last tkeep: pulse tx_bad_keep.
//    Non-last beat is treated as FF; last beat uses n.
//  tx_rst mid-frame: next cycle reset values; partial frame is abandoned, no error block emitted.
// CONFIGURATION
//  `XGMII_TX_STATS_EN defined: stat_tx_frames += 1 and stat_tx_bytes += 8*beats-8+n on each clean terminate.
//    Counters wrap modulo 2^STAT_WIDTH; cleared by tx_rst.
//  Undefined: both stat ports tied to 0, counter logic absent.
// STRUCTURE
//  Package eth_xgmii_pkg: XGMII code localparams (IDLE/START/TERM/ERROR/PRE/SFD), state enum,
//    IDLE_WORD 64'h0707070707070707.
//  Sub-module eth_xgmii_term_encode: combinational; tdata, n, err -> txd/txc for the last beat.
// TESTING
//  1 64-byte frame, 8 beats, last tkeep=FF.
//    -> start block D5555555555555FB/01, 8 data words txc=00, then 07070707070707FD/FF, 1 idle block, next start.
//  2 60-byte frame, last tkeep=0F.
//    -> term word {07,07,07,FD,d3..d0} txc=F0; exactly 1 idle block before next start.
//  3 Back-to-back frames, last tkeep=7F (k=7).
//    -> 2 idle blocks between term and next start; tready=0 throughout.
//  4 tvalid dropped after beat 3 of 8.
//    -> 070707070707FDFE/FF, tx_underrun pulse 1 cycle; beats 4-8 consumed with idles on wire.
//  5 tuser=1 with last tkeep=FF.
//    -> last word FEFEFEFEFEFEFEFE/FF, then term block; with macro, stat_tx_frames unchanged.
//  6 tx_rst asserted during DATA; then a 64-byte frame.
//    -> idle/FF next cycle, tready=0; clean frame follows; with macro, stats=1 frame/64 bytes.

Source files
------------

// File: rtl/eth_xgmii_pkg.sv
// Shared XGMII control codes, canned words, framer state type and tkeep helpers.
package eth_xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_PRE   = 8'h55;
    localparam logic [7:0] XGMII_SFD   = 8'hD5;

    localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};
    localparam logic [63:0] START_WORD = {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START};
    localparam logic [63:0] TERM_WORD  = {{7{XGMII_IDLE}}, XGMII_TERM};
    localparam logic [63:0] ABORT_WORD = {{6{XGMII_IDLE}}, XGMII_TERM, XGMII_ERROR};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_TERM,
        ST_IFG,
        ST_DROP
    } tx_state_t;

    // Index of the lowest cleared tkeep bit; 8 when every lane is valid.
    function automatic logic [3:0] first_zero(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 7; i >= 0; i--)
            if (!keep[i]) n = 4'(i);
        return n;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'h1 << n) - 9'h1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/eth_xgmii_term_encode.sv
// Builds the XGMII word for the last beat of a frame: n valid lanes, then terminate, then idles.
module eth_xgmii_term_encode
    import eth_xgmii_pkg::*;
(
    input  logic [63:0] tdata,
    input  logic [3:0]  n,
    input  logic        err,
    output logic [63:0] txd,
    output logic [7:0]  txc
);

    always_comb begin
        txd = '0;
        txc = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) begin
                // A poisoned frame carries error codes in place of its data lanes.
                txd[8*i +: 8] = err ? XGMII_ERROR : tdata[8*i +: 8];
                txc[i]        = err;
            end else if (4'(i) == n) begin
                txd[8*i +: 8] = XGMII_TERM;
                txc[i]        = 1'b1;
            end else begin
                txd[8*i +: 8] = XGMII_IDLE;
                txc[i]        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_xgmii_tx_framer.sv
// 64-bit AXI-Stream to XGMII TX framer: start/preamble, terminate, minimum IFG, underrun abort.
// Define XGMII_TX_STATS_EN to build the frame/byte statistics counters.
module eth_xgmii_tx_framer
    import eth_xgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int IFG_BYTES  = 12,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CTRL_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] xgmii_txd,
    output logic [CTRL_WIDTH-1:0] xgmii_txc,
    output logic                  tx_underrun,
    output logic                  tx_bad_keep,
    output logic [STAT_WIDTH-1:0] stat_tx_frames,
    output logic [STAT_WIDTH-1:0] stat_tx_bytes
);

    localparam logic [6:0] IFG_MIN = 7'(IFG_BYTES);

    tx_state_t             state;
    logic [6:0]            ifg_cnt;
    logic [6:0]            ifg_inc;
    logic [6:0]            term_gap;
    logic [3:0]            last_n;
    logic                  last_contig;
    logic [DATA_WIDTH-1:0] term_txd;
    logic [CTRL_WIDTH-1:0] term_txc;

    assign last_n      = first_zero(s_axis_tkeep);
    assign last_contig = (s_axis_tkeep == keep_mask(last_n));
    // Idle lanes after FD in the terminate word already count toward the gap.
    assign term_gap    = {3'b0, 4'd8 - last_n};
    assign ifg_inc     = (ifg_cnt < IFG_MIN) ? ifg_cnt + 7'd8 : ifg_cnt;

    eth_xgmii_term_encode u_term (
        .tdata (s_axis_tdata),
        .n     (last_n),
        .err   (s_axis_tuser),
        .txd   (term_txd),
        .txc   (term_txc)
    );

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state         <= ST_IDLE;
            xgmii_txd     <= IDLE_WORD;
            xgmii_txc     <= '1;
            s_axis_tready <= 1'b0;
            tx_underrun   <= 1'b0;
            tx_bad_keep   <= 1'b0;
            ifg_cnt       <= '0;
        end else begin
            tx_underrun <= 1'b0;
            tx_bad_keep <= 1'b0;
            case (state)
                ST_IDLE: begin
                    xgmii_txd <= IDLE_WORD;
                    xgmii_txc <= '1;
                    if (s_axis_tvalid) begin
                        xgmii_txd     <= START_WORD;
                        xgmii_txc     <= 8'h01;
                        s_axis_tready <= 1'b1;
                        state         <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE, ST_DATA: begin
                    if (!s_axis_tvalid) begin
                        xgmii_txd   <= ABORT_WORD;
                        xgmii_txc   <= '1;
                        tx_underrun <= 1'b1;
                        ifg_cnt     <= 7'd7;
                        state       <= ST_DROP;
                    end else if (!s_axis_tlast) begin
                        xgmii_txd   <= s_axis_tdata;
                        xgmii_txc   <= '0;
                        tx_bad_keep <= (s_axis_tkeep != '1);
                        state       <= ST_DATA;
                    end else begin
                        xgmii_txd     <= term_txd;
                        xgmii_txc     <= term_txc;
                        tx_bad_keep   <= !last_contig;
                        s_axis_tready <= 1'b0;
                        if (last_n == 4'd8) begin
                            state <= ST_TERM;
                        end else begin
                            ifg_cnt <= term_gap;
                            state   <= (term_gap >= IFG_MIN) ? ST_IDLE : ST_IFG;
                        end
                    end
                end
                ST_TERM: begin
                    xgmii_txd <= TERM_WORD;
                    xgmii_txc <= '1;
                    ifg_cnt   <= 7'd8;
                    state     <= (7'd8 >= IFG_MIN) ? ST_IDLE : ST_IFG;
                end
                ST_IFG: begin
                    xgmii_txd <= IDLE_WORD;
                    xgmii_txc <= '1;
                    ifg_cnt   <= ifg_inc;
                    if (ifg_inc >= IFG_MIN) state <= ST_IDLE;
                end
                ST_DROP: begin
                    xgmii_txd <= IDLE_WORD;
                    xgmii_txc <= '1;
                    ifg_cnt   <= ifg_inc;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        s_axis_tready <= 1'b0;
                        state         <= (ifg_inc >= IFG_MIN) ? ST_IDLE : ST_IFG;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef XGMII_TX_STATS_EN
    logic                  in_frame;
    logic [STAT_WIDTH-1:0] frames_q;
    logic [STAT_WIDTH-1:0] bytes_q;
    logic [STAT_WIDTH-1:0] beats_q;

    assign in_frame = (state == ST_PREAMBLE) || (state == ST_DATA);

    // beats_q counts the full beats before the last one of the current frame.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            frames_q <= '0;
            bytes_q  <= '0;
            beats_q  <= '0;
        end else if (in_frame && s_axis_tvalid) begin
            if (!s_axis_tlast) begin
                beats_q <= beats_q + STAT_WIDTH'(1);
            end else begin
                beats_q <= '0;
                if (!s_axis_tuser) begin
                    frames_q <= frames_q + STAT_WIDTH'(1);
                    bytes_q  <= bytes_q + (beats_q << 3) + STAT_WIDTH'(last_n);
                end
            end
        end else if (state == ST_IDLE) begin
            beats_q <= '0;
        end
    end

    assign stat_tx_frames = frames_q;
    assign stat_tx_bytes  = bytes_q;
`else
    assign stat_tx_frames = '0;
    assign stat_tx_bytes  = '0;
`endif

endmodule
